// File: rtl/fetch_stage.sv
// Front-end fetch: PC, one-line buffer, cache miss handling and packet slicing.
// Optional FETCH_LINE_BUFFER_EN keeps the buffered line alive across transfers and redirects.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | serve packets from the line buffer, or issue a miss
// ST_WAIT | cache request outstanding, response fills the buffer
// ST_DROP | request outstanding but squashed by a redirect
module fetch_stage #(
    parameter int          FETCH_WIDTH = 4,
    parameter logic [31:0] RESET_PC    = 32'haaaaa000
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [31:0]                    ufp_addr,
    output logic [3:0]                     ufp_rmask,
    input  logic [255:0]                   ufp_rcache_line,
    input  logic                           ufp_resp,
    output logic                           fetch_valid,
    input  logic                           fetch_ready,
    output logic [$clog2(FETCH_WIDTH):0]   fetch_count,
    output logic [31:0]                    fetch_pc,
    output logic [63:0]                    fetch_order,
    output logic [32*FETCH_WIDTH-1:0]      fetch_inst,
    input  logic                           redirect,
    input  logic [31:0]                    redirect_pc
);

    localparam int         CW  = $clog2(FETCH_WIDTH) + 1;
    localparam logic [3:0] FW4 = 4'(FETCH_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [63:0]   order;
    logic [26:0]   lb_tag;
    logic [255:0]  lb_data;
    logic          lb_valid;

    logic          hit;
    logic          pkt_valid;
    logic          transfer;
    logic          lb_drop;
    logic [2:0]    offset;
    logic [3:0]    room;
    logic [3:0]    count4;
    logic [255:0]  shifted;
    logic [31:0]   pc_next;
    logic [63:0]   order_next;
    logic          unused_bits;

    assign hit        = lb_valid && (lb_tag == pc[31:5]);
    assign offset     = pc[4:2];
    assign room       = 4'd8 - {1'b0, offset};
    assign count4     = (room < FW4) ? room : FW4;
    assign pkt_valid  = (state == ST_IDLE) && hit;
    assign transfer   = fetch_valid && fetch_ready;
    assign pc_next    = pc + {26'b0, count4, 2'b0};
    assign order_next = order + {60'b0, count4};
    assign shifted    = lb_data >> {offset, 5'b0};

    // Only redirect reaches fetch_valid combinationally; everything else is from registers.
    assign fetch_valid = pkt_valid && !redirect;
    assign fetch_count = pkt_valid ? count4[CW-1:0] : '0;
    assign fetch_pc    = pc;
    assign fetch_order = order;

    always_comb begin
        fetch_inst = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (pkt_valid && (4'(i) < count4)) begin
                fetch_inst[32*i +: 32] = shifted[32*i +: 32];
            end
        end
    end

`ifdef FETCH_LINE_BUFFER_EN
    assign lb_drop = 1'b0;
`else
    // A response landing with the redirect still carries a correctly tagged line.
    assign lb_drop = transfer || (redirect && !((state == ST_WAIT) && ufp_resp));
`endif

    assign unused_bits = ^{redirect_pc[1:0], shifted};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            order     <= '0;
            lb_tag    <= '0;
            lb_data   <= '0;
            lb_valid  <= 1'b0;
            ufp_addr  <= '0;
            ufp_rmask <= '0;
        end else begin
            if (redirect) begin
                pc <= {redirect_pc[31:2], 2'b0};
            end else if (transfer) begin
                pc    <= pc_next;
                order <= order_next;
            end

            if (lb_drop) begin
                lb_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!redirect && !hit) begin
                        ufp_addr  <= {pc[31:5], 5'b0};
                        ufp_rmask <= 4'hf;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ufp_resp) begin
                        lb_data   <= ufp_rcache_line;
                        lb_tag    <= ufp_addr[31:5];
                        lb_valid  <= 1'b1;
                        ufp_rmask <= '0;
                        state     <= ST_IDLE;
                    end else if (redirect) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (ufp_resp) begin
                        ufp_rmask <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    ufp_rmask <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (FETCH_WIDTH=4); follows FETCH_LINE_BUFFER_EN if defined.
module tb_fetch_stage;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ufp_addr;
    logic [3:0]    ufp_rmask;
    logic [255:0]  ufp_rcache_line;
    logic          ufp_resp;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [2:0]    fetch_count;
    logic [31:0]   fetch_pc;
    logic [63:0]   fetch_order;
    logic [127:0]  fetch_inst;
    logic          redirect;
    logic [31:0]   redirect_pc;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.FETCH_WIDTH(4), .RESET_PC(32'haaaaa000)) dut (
        .clk(clk), .rst(rst),
        .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask),
        .ufp_rcache_line(ufp_rcache_line), .ufp_resp(ufp_resp),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_count(fetch_count), .fetch_pc(fetch_pc),
        .fetch_order(fetch_order), .fetch_inst(fetch_inst),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory image: word at byte address a is 0x100 + (a - 0xaaaaa000)/4.
    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'h100 + ((a - 32'haaaaa000) >> 2);
    endfunction

    function automatic logic [255:0] make_line(input logic [31:0] a);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = w({a[31:5], 5'b0} + 32'(4*i));
        return l;
    endfunction

    function automatic logic [127:0] exp_inst(input logic [31:0] p, input int cnt);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < cnt; i++) r[32*i +: 32] = w(p + 32'(4*i));
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a request, then answers after lat cycles with the line at a.
    task automatic serve(input logic [31:0] a, input int lat, output bit ok, output logic [31:0] seen);
        for (int i = 0; i < 10 && ufp_rmask !== 4'hf; i++) tick();
        ok   = (ufp_rmask === 4'hf);
        seen = ufp_addr;
        if (ok) begin
            for (int i = 1; i < lat; i++) tick();
            ufp_rcache_line = make_line(a);
            ufp_resp = 1'b1;
            tick();
            ufp_resp = 1'b0;
            ufp_rcache_line = '0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ufp_resp = 1'b0; ufp_rcache_line = '0; fetch_ready = 1'b0;
        tick(); tick();
        checks++; if ({ufp_rmask, ufp_addr} !== 36'h0) begin errors++; $display("FAIL reset_ufp: got %h want 0", {ufp_rmask, ufp_addr}); end
        checks++; if ({fetch_valid, fetch_count, fetch_inst} !== 132'h0) begin errors++; $display("FAIL reset_fetch: got %h want 0", {fetch_valid, fetch_count, fetch_inst}); end
        #2 rst = 1'b1;
        tick();
        checks++; if ({ufp_rmask, ufp_addr} !== {4'hf, 32'haaaaa000}) begin errors++; $display("FAIL first_req: got %h want faaaaa000", {ufp_rmask, ufp_addr}); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL first_req_valid: got %b want 0", fetch_valid); end
    endtask

    task automatic test_miss_fetch;
        bit ok; logic [31:0] seen;
        serve(32'haaaaa000, 3, ok, seen);
        checks++; if (!ok || seen !== 32'haaaaa000) begin errors++; $display("FAIL miss1_req: got ok=%0d addr=%h want ok=1 addr=aaaaa000", ok, seen); end
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd4, 32'haaaaa000, 64'd0, 128'h00000103_00000102_00000101_00000100})
            begin errors++; $display("FAIL pkt1: got %h want packet pc=aaaaa000 order=0 inst 100..103", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
        checks++; if (ufp_rmask !== 4'h0) begin errors++; $display("FAIL rmask_after_resp: got %h want 0", ufp_rmask); end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
`ifndef FETCH_LINE_BUFFER_EN
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL no_back_to_back: got %b want 0", fetch_valid); end
        serve(32'haaaaa000, 1, ok, seen);
        checks++; if (!ok || seen !== 32'haaaaa000) begin errors++; $display("FAIL miss2_req: got ok=%0d addr=%h want ok=1 addr=aaaaa000", ok, seen); end
`endif
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd4, 32'haaaaa010, 64'd4, 128'h00000107_00000106_00000105_00000104})
            begin errors++; $display("FAIL pkt2: got %h want packet pc=aaaaa010 order=4 inst 104..107", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL line_end_miss: got %b want 0", fetch_valid); end
        tick();
        checks++; if ({ufp_rmask, ufp_addr} !== {4'hf, 32'haaaaa020}) begin errors++; $display("FAIL req_020: got %h want faaaaa020", {ufp_rmask, ufp_addr}); end
        serve(32'haaaaa020, 2, ok, seen);
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd4, 32'haaaaa020, 64'd8, 128'h0000010b_0000010a_00000109_00000108})
            begin errors++; $display("FAIL pkt3: got %h want packet pc=aaaaa020 order=8 inst 108..10b", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
    endtask

    task automatic test_redirect_hit;
        bit ok; logic [31:0] seen;
        fetch_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'haaaaa03b;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL redirect_kills_valid: got %b want 0", fetch_valid); end
        tick(); redirect = 1'b0; fetch_ready = 1'b0;
`ifndef FETCH_LINE_BUFFER_EN
        serve(32'haaaaa020, 1, ok, seen);
        checks++; if (!ok || seen !== 32'haaaaa020) begin errors++; $display("FAIL redir_refetch: got ok=%0d addr=%h want ok=1 addr=aaaaa020", ok, seen); end
`endif
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd2, 32'haaaaa038, 64'd8, 128'h00000000_00000000_0000010f_0000010e})
            begin errors++; $display("FAIL pkt_redir: got %h want count=2 pc=aaaaa038 order=8 inst 10e,10f", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL after_short_pkt: got %b want 0", fetch_valid); end
        tick();
        checks++; if ({ufp_rmask, ufp_addr} !== {4'hf, 32'haaaaa040}) begin errors++; $display("FAIL req_040: got %h want faaaaa040", {ufp_rmask, ufp_addr}); end
    endtask

    task automatic test_redirect_drop;
        bit ok; logic [31:0] seen;
        redirect = 1'b1; redirect_pc = 32'haaaaa044;
        tick(); redirect = 1'b0;
        checks++; if ({ufp_rmask, ufp_addr} !== {4'hf, 32'haaaaa040}) begin errors++; $display("FAIL drop_hold1: got %h want faaaaa040", {ufp_rmask, ufp_addr}); end
        tick();
        checks++; if ({ufp_rmask, fetch_valid} !== {4'hf, 1'b0}) begin errors++; $display("FAIL drop_hold2: got %h want 1e", {ufp_rmask, fetch_valid}); end
        ufp_rcache_line = make_line(32'haaaaa040); ufp_resp = 1'b1;
        tick(); ufp_resp = 1'b0; ufp_rcache_line = '0;
        checks++; if ({ufp_rmask, fetch_valid} !== 5'h0) begin errors++; $display("FAIL drop_discard: got %h want 0", {ufp_rmask, fetch_valid}); end
        tick();
        checks++; if ({ufp_rmask, ufp_addr} !== {4'hf, 32'haaaaa040}) begin errors++; $display("FAIL drop_rerequest: got %h want faaaaa040", {ufp_rmask, ufp_addr}); end
        serve(32'haaaaa040, 1, ok, seen);
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd4, 32'haaaaa044, 64'd10, 128'h00000114_00000113_00000112_00000111})
            begin errors++; $display("FAIL pkt_044: got %h want pc=aaaaa044 order=10 inst 111..114", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
    endtask

    task automatic test_backpressure;
        bit ok; logic [31:0] seen;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst, ufp_rmask} !== {1'b1, 3'd4, 32'haaaaa044, 64'd10, 128'h00000114_00000113_00000112_00000111, 4'h0})
                begin errors++; $display("FAIL stall_%0d: got %h want packet held at pc=aaaaa044 order=10", c, {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
        end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
`ifndef FETCH_LINE_BUFFER_EN
        serve(32'haaaaa040, 1, ok, seen);
        checks++; if (!ok || seen !== 32'haaaaa040) begin errors++; $display("FAIL stall_refetch: got ok=%0d addr=%h want ok=1 addr=aaaaa040", ok, seen); end
`endif
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd3, 32'haaaaa054, 64'd14, 128'h00000000_00000117_00000116_00000115})
            begin errors++; $display("FAIL pkt_054: got %h want count=3 pc=aaaaa054 order=14", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
    endtask

    task automatic test_redirect_vs_transfer;
        bit ok; logic [31:0] seen;
        fetch_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h00002006;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rvt_valid: got %b want 0", fetch_valid); end
        tick(); redirect = 1'b0; fetch_ready = 1'b0;
        serve(32'h00002000, 2, ok, seen);
        checks++; if (!ok || seen !== 32'h00002000) begin errors++; $display("FAIL rvt_req: got ok=%0d addr=%h want ok=1 addr=00002000", ok, seen); end
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd4, 32'h00002004, 64'd14, exp_inst(32'h00002004, 4)})
            begin errors++; $display("FAIL rvt_pkt: got %h want pc=00002004 order=14 count=4", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
    endtask

    task automatic test_line_end;
        bit ok; logic [31:0] seen;
        redirect = 1'b1; redirect_pc = 32'haaaaa0bc;
        tick(); redirect = 1'b0;
        serve(32'haaaaa0a0, 1, ok, seen);
        checks++; if (!ok || seen !== 32'haaaaa0a0) begin errors++; $display("FAIL le_req: got ok=%0d addr=%h want ok=1 addr=aaaaa0a0", ok, seen); end
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd1, 32'haaaaa0bc, 64'd14, 128'h0000012f})
            begin errors++; $display("FAIL le_pkt: got %h want count=1 pc=aaaaa0bc order=14 inst 12f", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
        tick();
        checks++; if ({ufp_rmask, ufp_addr} !== {4'hf, 32'haaaaa0c0}) begin errors++; $display("FAIL le_next: got %h want faaaaa0c0", {ufp_rmask, ufp_addr}); end
    endtask

    task automatic test_reset_mid_wait;
        bit ok; logic [31:0] seen;
        #3 rst = 1'b0;
        #1;
        checks++; if ({ufp_rmask, fetch_valid, fetch_count} !== 8'h0) begin errors++; $display("FAIL async_reset: got %h want 0", {ufp_rmask, fetch_valid, fetch_count}); end
        #1 rst = 1'b1;
        tick();
        checks++; if ({ufp_rmask, ufp_addr} !== {4'hf, 32'haaaaa000}) begin errors++; $display("FAIL restart_req: got %h want faaaaa000", {ufp_rmask, ufp_addr}); end
        serve(32'haaaaa000, 1, ok, seen);
        checks++; if ({fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst} !== {1'b1, 3'd4, 32'haaaaa000, 64'd0, 128'h00000103_00000102_00000101_00000100})
            begin errors++; $display("FAIL restart_pkt: got %h want pc=aaaaa000 order=0 inst 100..103", {fetch_valid, fetch_count, fetch_pc, fetch_order, fetch_inst}); end
    endtask

    initial begin
        test_reset();
        test_miss_fetch();
        test_redirect_hit();
        test_redirect_drop();
        test_backpressure();
        test_redirect_vs_transfer();
        test_line_end();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised front-end fetch block sitting between the instruction cache upstream-facing port and the instruction queue. It holds a PC and a one-line (256-bit) line buffer, requests cache lines on a miss, and slices up to `FETCH_WIDTH` sequential instructions per cycle into a fetch packet. The packet is tagged with PC and a 64-bit commit order. It also accepts a redirect (flush) from the back end and squashes any in-flight cache response. It replaces the single-instruction fetch logic inside the core top level.

## Interface
Parameters:
- `FETCH_WIDTH`, default 4: max instructions per packet; legal values are 1, 2, 4 and 8.
- `RESET_PC`, default 32'haaaaa000: PC after reset.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ufp_addr` output 32: line-aligned cache request address, {pc[31:5],5'b0}.
- `ufp_rmask` output 4: 4'b1111 while a request is outstanding, else 0.
- `ufp_rcache_line` input 256: line data, valid when `ufp_resp`=1.
- `ufp_resp` input 1: single-cycle cache response.
- `fetch_valid` output 1: packet valid.
- `fetch_ready` input 1: downstream queue can accept the packet.
- `fetch_count` output $clog2(FETCH_WIDTH)+1: number of valid lanes, 1..FETCH_WIDTH.
- `fetch_pc` output 32: PC of lane 0; lane i PC = fetch_pc+4i.
- `fetch_order` output 64: order of lane 0; lane i order = fetch_order+i.
- `fetch_inst` output 32*FETCH_WIDTH: lane i in bits [32i+:32]; lanes ≥ count are 0.
- `redirect` input 1: flush and restart at `redirect_pc`.
- `redirect_pc` input 32: new PC; bits [1:0] ignored (forced 0).

## Operation
- Registers:
  - `pc`
  - `order`
  - `lb_tag` [31:5]
  - `lb_data` 256
  - `lb_valid`
  - `state` ∈ {IDLE, WAIT, DROP}
- Hit = `lb_valid` && `lb_tag`==pc[31:5].
- Lane count is min(FETCH_WIDTH, 8−pc[4:2]). A packet never crosses a line. Lane i = lb_data[32*(pc[4:2]+i)+:32].
- IDLE:
  - `fetch_valid` = hit && !redirect.
  - Transfer (valid && ready): pc += 4*count and order += count.
  - On a miss, register ufp_addr and ufp_rmask=1111, then go to WAIT.
- WAIT:
  - ufp_rmask and ufp_addr are held stable.
  - On `ufp_resp`: lb_data←line, lb_tag←ufp_addr[31:5], lb_valid←1, ufp_rmask←0, go to IDLE.
- DROP:
  - Same as WAIT (the cache transaction must complete).
  - On `ufp_resp`: discard the data, leave lb unchanged, ufp_rmask←0, go to IDLE.
- Redirect (highest priority, any state):
  - pc←{redirect_pc[31:2],2'b0}. `order` is not reset.
  - `fetch_valid` is forced 0 in that cycle, so no transfer occurs.
  - WAIT without ufp_resp goes to DROP. WAIT with ufp_resp in the same cycle captures the line (tag is correct) and goes to IDLE.
  - DROP stays DROP; a ufp_resp in that cycle goes to IDLE.
  - IDLE stays IDLE.
- Arithmetic:
  - pc wraps modulo 2^32.
  - order wraps modulo 2^64.
  - count is computed in 4-bit arithmetic before truncating to the port width.

## Timing
- Reset values (asserted asynchronously, held until release):
  - pc=RESET_PC, order=0, lb_valid=0, state=IDLE.
  - ufp_rmask=0, ufp_addr=0.
  - fetch_valid=0, fetch_count=0, fetch_inst=0.
- Reset mid-request: the outstanding cache transaction is abandoned; the cache is reset by the same signal.
- First clock after reset release: IDLE detects a miss. The next cycle has ufp_rmask=1111.
- Miss latency: ufp_resp at cycle k gives fetch_valid=1 at cycle k+1 (lb registered, outputs combinational from registers).
- Hit throughput: one packet per cycle while fetch_ready=1.
- fetch_valid low with state IDLE and a miss means a request is issued the next cycle.
- Back-pressure: with fetch_ready=0, the packet (all outputs) is held stable until accepted or redirected.
- Combinational paths:
  - redirect→fetch_valid only.
  - No path from fetch_ready to any output.

## Configuration
- `FETCH_LINE_BUFFER_EN` defined:
  - lb_valid persists across transfers and redirects.
  - Sequential packets and backward redirects within the buffered line hit without a cache access.
- Undefined:
  - lb_valid←0 on every transfer and on every redirect that is not coincident with ufp_resp.
  - Every packet costs one cache request.
  - fetch_valid is never asserted on two consecutive cycles.

## Test plan
- Reset release, FETCH_WIDTH=4, cache returns line at 0xaaaaa000 with words 0..7 = 0x100+i after 3 cycles → ufp_addr=0xaaaaa000. Packet 1: pc 0xaaaaa000, count 4, inst 0x100..0x103, order 0. Packet 2 (buffer EN): pc 0xaaaaa010, order 4. Then a request to 0xaaaaa020.
- Redirect to 0xaaaaa018 with the line buffered → packet count 2, inst 0x106/0x107. Lanes 2–3 are zero. The next pc is 0xaaaaa020.
- Redirect asserted one cycle into WAIT; cache response arrives 2 cycles later → ufp_rmask stays 1111 through the response. The line is discarded and fetch_valid stays 0. A new request goes to the redirect line.
- fetch_ready held 0 for 5 cycles on a valid packet → all packet outputs are stable; pc/order advance only on the accepting cycle.
- Redirect coincident with valid&&ready → no transfer, order unchanged. The next packet carries the redirect pc and the same order.
- rst pulsed low mid-WAIT (asynchronous, between edges) → ufp_rmask=0 and fetch_valid=0 immediately. After release, the fetch restarts at RESET_PC with order 0.
